// File: rtl/clock_divider_bank.sv
// Bank of independent programmable clock dividers with per-channel enable and divisor write port.
// Define CLKDIV_SHADOW_EN to defer divisor writes to running channels until the period boundary.
module clock_divider_bank #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_WIDTH   = 19,
    parameter int unsigned DEFAULT_DIV = 500,
    localparam int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [CHANNELS-1:0]  enable_i,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [CH_W-1:0]      wr_chan_i,
    input  logic [CNT_WIDTH-1:0] wr_div_i,
    output logic [CHANNELS-1:0]  div_clk_o,
    output logic [CHANNELS-1:0]  div_tick_o,
    output logic [CHANNELS-1:0]  pending_o
);

    localparam logic [CNT_WIDTH-1:0] DefDiv = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] MinDiv = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] One    = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_d [CHANNELS];
    logic [CNT_WIDTH-1:0] act_q [CHANNELS];
    logic [CNT_WIDTH-1:0] act_d [CHANNELS];
    logic [CHANNELS-1:0]  run_q;
    logic [CHANNELS-1:0]  clk_q, clk_d;
    logic [CHANNELS-1:0]  tick_q, tick_d;
    logic [CHANNELS-1:0]  wrap;
    logic [CHANNELS-1:0]  restart;
    logic [CHANNELS-1:0]  wr_hit;
    logic [CNT_WIDTH-1:0] wr_div_clamped;

    assign wr_div_clamped = (wr_div_i < MinDiv) ? MinDiv : wr_div_i;

    // Out-of-range channel numbers match no channel, so such writes are silently dropped.
    always_comb begin
        wr_hit = '0;
        wrap   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_hit[i] = wr_valid_i && wr_ready_o && (wr_chan_i == CH_W'(i));
            wrap[i]   = run_q[i] && (cnt_q[i] == act_q[i] - One);
        end
    end

`ifdef CLKDIV_SHADOW_EN
    logic [CNT_WIDTH-1:0] shd_q [CHANNELS];
    logic [CNT_WIDTH-1:0] shd_d [CHANNELS];
    logic [CHANNELS-1:0]  pend_q, pend_d;

    always_comb begin
        wr_ready_o = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_chan_i == CH_W'(i)) begin
                wr_ready_o = !pend_q[i];
            end
        end
    end

    // A write is never accepted while pending, so the load and write branches never collide.
    always_comb begin
        pend_d  = pend_q;
        restart = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            act_d[i] = act_q[i];
            shd_d[i] = shd_q[i];
            if (pend_q[i] && (wrap[i] || !enable_i[i])) begin
                act_d[i]  = shd_q[i];
                pend_d[i] = 1'b0;
            end
            if (wr_hit[i]) begin
                if (enable_i[i]) begin
                    shd_d[i]  = wr_div_clamped;
                    pend_d[i] = 1'b1;
                end else begin
                    act_d[i] = wr_div_clamped;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                shd_q[i] <= DefDiv;
            end
        end else begin
            pend_q <= pend_d;
            for (int i = 0; i < CHANNELS; i++) begin
                shd_q[i] <= shd_d[i];
            end
        end
    end

    assign pending_o = pend_q;
`else
    assign wr_ready_o = 1'b1;
    assign pending_o  = '0;

    always_comb begin
        restart = wr_hit;
        for (int i = 0; i < CHANNELS; i++) begin
            act_d[i] = wr_hit[i] ? wr_div_clamped : act_q[i];
        end
    end
`endif

    // Outputs are registered from next-state values so they line up with cnt_q in each cycle.
    always_comb begin
        clk_d  = '0;
        tick_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!enable_i[i] || !run_q[i] || wrap[i] || restart[i]) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + One;
            end
            clk_d[i]  = enable_i[i] && (cnt_d[i] >= (act_d[i] >> 1));
            tick_d[i] = enable_i[i] && (cnt_d[i] == act_d[i] - One);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q  <= '0;
            clk_q  <= '0;
            tick_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
                act_q[i] <= DefDiv;
            end
        end else begin
            run_q  <= enable_i;
            clk_q  <= clk_d;
            tick_q <= tick_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
                act_q[i] <= act_d[i];
            end
        end
    end

    assign div_clk_o  = clk_q;
    assign div_tick_o = tick_q;

endmodule
